// File: rtl/me_search_ctrl.sv
// me_search_ctrl
//   Sequencer and result collector for the motion-estimation datapath.
//   A block-start pulse starts a count through the pipeline fill. The block
//   then samples the per-cycle minimum SAD and row index for N_COLS candidate
//   columns, keeps the running best, and commits one motion vector per block
//   to a valid/ready output register.
//
// Ports
//   clk, rst               : clock, synchronous active-high reset
//   en                     : datapath enable; the FSM and counters hold when low
//   next_block             : block-start pulse
//   msad_i, msad_idx_i     : current-cycle minimum SAD and its row index
//   mv_valid_o, mv_ready_i : result handshake
//   mv_col_o, mv_row_o     : best column / row of the committed result
//   mv_sad_o               : best SAD of the committed result
//   block_cnt_o            : completed-block count, wraps at 16 bits
//   busy_o                 : FSM is not idle
//   overflow_o             : sticky, an unaccepted result was overwritten
//   restart_o              : one-cycle pulse after a block is aborted
module me_search_ctrl #(
    parameter int SAD_BIT_WIDTH = 14,
    parameter int IDX_WIDTH     = 4,
    parameter int COL_WIDTH     = 4,
    parameter int N_COLS        = 16,
    parameter int PIPE_LAT      = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     next_block,
    input  logic [SAD_BIT_WIDTH-1:0] msad_i,
    input  logic [IDX_WIDTH-1:0]     msad_idx_i,
    output logic                     mv_valid_o,
    input  logic                     mv_ready_i,
    output logic [COL_WIDTH-1:0]     mv_col_o,
    output logic [IDX_WIDTH-1:0]     mv_row_o,
    output logic [SAD_BIT_WIDTH-1:0] mv_sad_o,
    output logic [15:0]              block_cnt_o,
    output logic                     busy_o,
    output logic                     overflow_o,
    output logic                     restart_o
);

    localparam int LAT_W = $clog2(PIPE_LAT + 1);
    localparam logic [LAT_W-1:0]     LAT_LAST = LAT_W'(PIPE_LAT - 1);
    localparam logic [COL_WIDTH-1:0] COL_LAST = COL_WIDTH'(N_COLS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        SEARCH = 2'd2
    } state_t;

    state_t                   state;
    logic [LAT_W-1:0]         lat_cnt;
    logic [COL_WIDTH-1:0]     col_cnt;
    logic [SAD_BIT_WIDTH-1:0] best_sad;
    logic [COL_WIDTH-1:0]     best_col;
    logic [IDX_WIDTH-1:0]     best_row;

    // The final sample's compare has to be folded into the committed result,
    // so the winner of this cycle's compare is formed combinationally.
    logic                     take;
    logic                     commit;
    logic [SAD_BIT_WIDTH-1:0] fin_sad;
    logic [COL_WIDTH-1:0]     fin_col;
    logic [IDX_WIDTH-1:0]     fin_row;

    always_comb begin
        take    = msad_i < best_sad;   // strict: ties keep the earlier column
        fin_sad = take ? msad_i     : best_sad;
        fin_col = take ? col_cnt    : best_col;
        fin_row = take ? msad_idx_i : best_row;
        commit  = en && (state == SEARCH) && (col_cnt == COL_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            lat_cnt     <= '0;
            col_cnt     <= '0;
            best_sad    <= '1;
            best_col    <= '0;
            best_row    <= '0;
            mv_valid_o  <= 1'b0;
            mv_col_o    <= '0;
            mv_row_o    <= '0;
            mv_sad_o    <= '0;
            block_cnt_o <= '0;
            busy_o      <= 1'b0;
            overflow_o  <= 1'b0;
            restart_o   <= 1'b0;
        end else begin
            restart_o <= 1'b0;

            if (en) begin
                if (state == SEARCH) begin
                    if (take) begin
                        best_sad <= msad_i;
                        best_col <= col_cnt;
                        best_row <= msad_idx_i;
                    end
                    col_cnt <= col_cnt + 1'b1;
                end

                if (state == FILL) begin
                    lat_cnt <= lat_cnt + 1'b1;
                    if (lat_cnt == LAT_LAST) begin
                        state    <= SEARCH;
                        col_cnt  <= '0;
                        best_sad <= '1;
                        best_col <= '0;
                        best_row <= '0;
                    end
                end

                if (commit) begin
                    state       <= IDLE;
                    busy_o      <= 1'b0;
                    block_cnt_o <= block_cnt_o + 16'd1;
                end

                // A start pulse overrides everything above. The pulse cycle
                // itself is the first latency cycle, so FILL starts counting
                // at 1 and SEARCH begins PIPE_LAT cycles after the pulse.
                if (next_block) begin
                    if (state != IDLE && !commit)
                        restart_o <= 1'b1;
                    state    <= (PIPE_LAT == 1) ? SEARCH : FILL;
                    lat_cnt  <= LAT_W'(1);
                    col_cnt  <= '0;
                    best_sad <= '1;
                    best_col <= '0;
                    best_row <= '0;
                    busy_o   <= 1'b1;
                end
            end

            // The output handshake runs regardless of en.
            if (commit) begin
                mv_valid_o <= 1'b1;
                mv_col_o   <= fin_col;
                mv_row_o   <= fin_row;
                mv_sad_o   <= fin_sad;
                if (mv_valid_o && !mv_ready_i)
                    overflow_o <= 1'b1;
            end else if (mv_valid_o && mv_ready_i) begin
                mv_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_me_search_ctrl.sv
// Directed bench for me_search_ctrl with default parameters.
module tb_me_search_ctrl;

    logic        clk = 1'b0;
    logic        rst, en, next_block, mv_ready_i;
    logic [13:0] msad_i;
    logic [3:0]  msad_idx_i;
    logic        mv_valid_o;
    logic [3:0]  mv_col_o, mv_row_o;
    logic [13:0] mv_sad_o;
    logic [15:0] block_cnt_o;
    logic        busy_o, overflow_o, restart_o;

    int n_cmp = 0;
    int n_err = 0;
    int lat;

    me_search_ctrl dut (
        .clk(clk), .rst(rst), .en(en), .next_block(next_block),
        .msad_i(msad_i), .msad_idx_i(msad_idx_i),
        .mv_valid_o(mv_valid_o), .mv_ready_i(mv_ready_i),
        .mv_col_o(mv_col_o), .mv_row_o(mv_row_o), .mv_sad_o(mv_sad_o),
        .block_cnt_o(block_cnt_o), .busy_o(busy_o),
        .overflow_o(overflow_o), .restart_o(restart_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Data for candidate column c; out-of-range c means "no sample should be
    // taken here", driven with a tiny SAD that would win if it were sampled.
    task automatic drive(input int pat, input int c);
        if (c < 0 || c > 15) begin
            msad_i = 14'd1;  msad_idx_i = 4'd9;
        end else begin
            case (pat)
                0: begin msad_i = 14'(1000 - 10 * c); msad_idx_i = 4'(c); end
                1: begin msad_i = 14'd500;            msad_idx_i = 4'((c + 3) % 16); end
                2: begin msad_i = 14'h3FFF;           msad_idx_i = 4'(c); end
                default: begin
                    msad_i = (c == 7) ? 14'd3 : 14'(1000 - 10 * c);
                    msad_idx_i = 4'(c);
                end
            endcase
        end
    endtask

    // Pulses next_block in the current cycle and runs until block_cnt_o moves.
    // lat = cycles from the (last) pulse to the commit becoming visible.
    // gate toggles en 1/0 each cycle; abort_col >= 0 re-pulses at that column.
    task automatic run_block(input int pat, input bit gate, input int abort_col, output int lat_o);
        logic [15:0] bc0;
        int  k, e, c;
        bit  done, aborted;
        bc0 = block_cnt_o;
        k = 0; e = 0; done = 0; aborted = 0;
        en = 1'b1; next_block = 1'b1;
        drive(pat, -1);
        while (!done && k < 200) begin
            step();
            k++;
            next_block = 1'b0;
            if (k == 1) begin
                check("busy_after_pulse", busy_o, 1);
                if (aborted) check("restart_pulse", restart_o, 1);
            end
            if (block_cnt_o != bc0) begin
                done = 1;
            end else begin
                en = gate ? ((k % 2) == 0) : 1'b1;
                if (en) e++;
                c = (en && e >= 8) ? e - 8 : -1;
                if (en && !aborted && abort_col >= 0 && c == abort_col) begin
                    next_block = 1'b1;
                    aborted = 1;
                    e = 0; k = 0; c = -1;
                end
                drive(pat, c);
            end
        end
        if (!done) check("block_timeout", 0, 1);
        en = 1'b1;
        drive(pat, -1);
        lat_o = k;
    endtask

    task automatic accept;
        mv_ready_i = 1'b1;
        step();
        check("valid_cleared", mv_valid_o, 0);
        mv_ready_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; next_block = 1'b0; mv_ready_i = 1'b0;
        msad_i = '0; msad_idx_i = '0;
        repeat (3) step();
        check("rst_valid", mv_valid_o, 0);
        check("rst_col", mv_col_o, 0);
        check("rst_row", mv_row_o, 0);
        check("rst_sad", mv_sad_o, 0);
        check("rst_blk", block_cnt_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_ovf", overflow_o, 0);
        check("rst_restart", restart_o, 0);
        rst = 1'b0;
        step();

        // Descending SAD: last column wins.
        run_block(0, 0, -1, lat);
        check("b1_lat", lat, 24);
        check("b1_valid", mv_valid_o, 1);
        check("b1_col", mv_col_o, 15);
        check("b1_row", mv_row_o, 15);
        check("b1_sad", mv_sad_o, 850);
        check("b1_blk", block_cnt_o, 1);
        check("b1_busy", busy_o, 0);
        accept();

        // All equal: first column kept.
        run_block(1, 0, -1, lat);
        check("eq_col", mv_col_o, 0);
        check("eq_row", mv_row_o, 3);
        check("eq_sad", mv_sad_o, 500);
        accept();

        // All-ones never beats the initial best.
        run_block(2, 0, -1, lat);
        check("max_col", mv_col_o, 0);
        check("max_row", mv_row_o, 0);
        check("max_sad", mv_sad_o, 14'h3FFF);
        accept();

        // en toggling every cycle: latency 47, column 7 wins.
        run_block(3, 1, -1, lat);
        check("gate_lat", lat, 47);
        check("gate_col", mv_col_o, 7);
        check("gate_row", mv_row_o, 7);
        check("gate_sad", mv_sad_o, 3);
        check("gate_blk", block_cnt_o, 4);
        accept();

        // Two results with ready low: overflow, second result visible.
        run_block(0, 0, -1, lat);
        check("ovf_pre", overflow_o, 0);
        run_block(1, 0, -1, lat);
        check("ovf_set", overflow_o, 1);
        check("ovf_valid", mv_valid_o, 1);
        check("ovf_col", mv_col_o, 0);
        check("ovf_row", mv_row_o, 3);
        check("ovf_sad", mv_sad_o, 500);
        check("ovf_blk", block_cnt_o, 6);
        accept();
        check("ovf_sticky", overflow_o, 1);

        // Abort at SEARCH column 5; latency measured from the second pulse.
        run_block(0, 0, 5, lat);
        check("abort_lat", lat, 24);
        check("abort_blk", block_cnt_o, 7);
        check("abort_col", mv_col_o, 15);
        check("abort_sad", mv_sad_o, 850);
        check("abort_restart_low", restart_o, 0);

        // Reset in the middle of SEARCH (valid and overflow are both set now).
        en = 1'b1; next_block = 1'b1; drive(0, -1);
        step();
        next_block = 1'b0;
        repeat (11) step();
        check("mid_busy", busy_o, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mrst_valid", mv_valid_o, 0);
        check("mrst_sad", mv_sad_o, 0);
        check("mrst_col", mv_col_o, 0);
        check("mrst_blk", block_cnt_o, 0);
        check("mrst_busy", busy_o, 0);
        check("mrst_ovf", overflow_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
